// File: rtl/link_stack_pkg.sv
// Shared CPU package: the default return-address stack depth and the address type
// used by the ID-stage link logic.
package link_stack_pkg;

  localparam int LINK_STACK_DEPTH = 8;
  localparam int ADDR_WIDTH       = 32;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/link_stack.sv
// Return-address stack for the ID stage: jal/jalr push, jr-through-link pops,
// and the NPC logic reads the predicted target from the top entry.
module link_stack
  import link_stack_pkg::*;
#(
  parameter int WIDTH     = ADDR_WIDTH,
  parameter int DEPTH     = LINK_STACK_DEPTH,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_addr,
  output logic [WIDTH-1:0]       top_addr,
  output logic                   top_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;

  logic          do_push;
  logic          do_pop;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          overflow_nxt;
  logic          underflow_nxt;

  // A held or flushed instruction must never touch the stack.
  assign do_push = push & ~stall & ~clr;
  assign do_pop  = pop & ~stall & ~clr;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  assign top_addr  = mem[ptr];
  assign top_valid = ~empty;

  // A push+pop on a non-empty stack replaces the top in place; on an empty
  // stack it degenerates into a plain push. Pointer arithmetic wraps because
  // DEPTH is a power of two.
  always_comb begin
    wr_en         = 1'b0;
    wr_idx        = ptr;
    ptr_nxt       = ptr;
    count_nxt     = count;
    overflow_nxt  = 1'b0;
    underflow_nxt = 1'b0;
    if (do_push && do_pop && !empty) begin
      wr_en = 1'b1;
    end else if (do_push) begin
      overflow_nxt = full;
      if (!full || OVERWRITE) begin
        wr_en   = 1'b1;
        wr_idx  = ptr + 1'b1;
        ptr_nxt = ptr + 1'b1;
        if (!full) begin
          count_nxt = count + 1'b1;
        end
      end
    end else if (do_pop) begin
      if (empty) begin
        underflow_nxt = 1'b1;
      end else begin
        ptr_nxt   = ptr - 1'b1;
        count_nxt = count - 1'b1;
      end
    end
  end

  // Every entry is cleared on reset so the stale top is well defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= push_addr;
      end
      ptr       <= ptr_nxt;
      count     <= count_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_link_stack.sv
// Directed bench for link_stack: two DEPTH=4 instances, one wrapping and one dropping
// when full, share the same stimulus and are checked against hand-computed values.
module tb_link_stack;
  import link_stack_pkg::*;

  logic  clk;
  logic  rst;
  logic  stall;
  logic  clr;
  logic  push;
  logic  pop;
  addr_t push_addr;

  addr_t      ow_top, dr_top;
  logic       ow_valid, dr_valid;
  logic [2:0] ow_count, dr_count;
  logic       ow_ovf, dr_ovf;
  logic       ow_unf, dr_unf;

  int total = 0;
  int bad   = 0;

  link_stack #(.WIDTH(32), .DEPTH(4), .OVERWRITE(1'b1)) dut_ow (
    .clk(clk), .rst(rst), .stall(stall), .clr(clr), .push(push), .pop(pop),
    .push_addr(push_addr), .top_addr(ow_top), .top_valid(ow_valid),
    .count(ow_count), .overflow(ow_ovf), .underflow(ow_unf)
  );

  link_stack #(.WIDTH(32), .DEPTH(4), .OVERWRITE(1'b0)) dut_dr (
    .clk(clk), .rst(rst), .stall(stall), .clr(clr), .push(push), .pop(pop),
    .push_addr(push_addr), .top_addr(dr_top), .top_valid(dr_valid),
    .count(dr_count), .overflow(dr_ovf), .underflow(dr_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one request for a single cycle, then idles the inputs 1 ns after the edge.
  task automatic applyStimulus(input logic p, input logic po, input addr_t a,
                               input logic s, input logic c);
    push = p; pop = po; push_addr = a; stall = s; clr = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; stall = 1'b0; clr = 1'b0;
  endtask

  task automatic checkState(input string tag, input int oc, input addr_t ot,
                            input int dc, input addr_t dt);
    checkOutput({tag, "/ow_count"}, 32'(ow_count), 32'(oc));
    checkOutput({tag, "/ow_top"}, ow_top, ot);
    checkOutput({tag, "/ow_valid"}, 32'(ow_valid), 32'(oc != 0));
    checkOutput({tag, "/dr_count"}, 32'(dr_count), 32'(dc));
    checkOutput({tag, "/dr_top"}, dr_top, dt);
    checkOutput({tag, "/dr_valid"}, 32'(dr_valid), 32'(dc != 0));
  endtask

  task automatic checkPulses(input string tag, input logic oo, input logic ou,
                             input logic do_, input logic du);
    checkOutput({tag, "/ow_ovf"}, 32'(ow_ovf), 32'(oo));
    checkOutput({tag, "/ow_unf"}, 32'(ow_unf), 32'(ou));
    checkOutput({tag, "/dr_ovf"}, 32'(dr_ovf), 32'(do_));
    checkOutput({tag, "/dr_unf"}, 32'(dr_unf), 32'(du));
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;
    #12;
    checkState("reset", 0, 32'h0, 0, 32'h0);
    checkPulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Push three, then pop them back in LIFO order
    applyStimulus(1, 0, 32'h100, 0, 0);
    applyStimulus(1, 0, 32'h200, 0, 0);
    applyStimulus(1, 0, 32'h300, 0, 0);
    checkState("push3", 3, 32'h300, 3, 32'h300);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("pop1", 2, 32'h200, 2, 32'h200);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("pop2", 1, 32'h100, 1, 32'h100);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("pop3", 0, 32'h0, 0, 32'h0);
    checkPulses("pop3", 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill both stacks, then push once more while full
    applyStimulus(1, 0, 32'h10, 0, 0);
    applyStimulus(1, 0, 32'h20, 0, 0);
    applyStimulus(1, 0, 32'h30, 0, 0);
    applyStimulus(1, 0, 32'h40, 0, 0);
    checkState("fill", 4, 32'h40, 4, 32'h40);
    checkPulses("fill", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 0, 32'h50, 0, 0);
    checkState("full_push", 4, 32'h50, 4, 32'h40);
    checkPulses("full_push", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkPulses("ovf_once", 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("drain1", 3, 32'h40, 3, 32'h30);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("drain2", 2, 32'h30, 2, 32'h20);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("drain3", 1, 32'h20, 1, 32'h10);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("drain4", 0, 32'h50, 0, 32'h40);
    checkPulses("drain4", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("pop_empty", 0, 32'h50, 0, 32'h40);
    checkPulses("pop_empty", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkPulses("unf_once", 1'b0, 1'b0, 1'b0, 1'b0);

    // Replace-top on a two-entry stack, then on an empty stack
    applyStimulus(1, 0, 32'hA, 0, 0);
    applyStimulus(1, 0, 32'hB, 0, 0);
    applyStimulus(1, 1, 32'hC, 0, 0);
    checkState("replace", 2, 32'hC, 2, 32'hC);
    checkPulses("replace", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("replace_pop", 1, 32'hA, 1, 32'hA);
    applyStimulus(0, 1, 32'h0, 0, 0);
    checkState("empty_again", 0, 32'h50, 0, 32'h40);
    applyStimulus(1, 1, 32'hD, 0, 0);
    checkState("pushpop_empty", 1, 32'hD, 1, 32'hD);
    checkPulses("pushpop_empty", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stalled or flushed requests must leave everything untouched
    applyStimulus(1, 0, 32'h44, 1, 0);
    checkState("stall_push", 1, 32'hD, 1, 32'hD);
    checkPulses("stall_push", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 0, 32'h44, 0, 1);
    checkState("clr_push", 1, 32'hD, 1, 32'hD);
    checkPulses("clr_push", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1, 32'h0, 0, 1);
    checkState("clr_pop", 1, 32'hD, 1, 32'hD);

    // Asynchronous reset between edges, then first push after release
    applyStimulus(1, 0, 32'h1, 0, 0);
    applyStimulus(1, 0, 32'h2, 0, 0);
    checkState("pre_reset", 3, 32'h2, 3, 32'h2);
    #3;
    rst = 1'b0;
    #1;
    checkState("async_reset", 0, 32'h0, 0, 32'h0);
    #2;
    rst = 1'b1;
    applyStimulus(1, 0, 32'h77, 0, 0);
    checkState("post_reset", 1, 32'h77, 1, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
